// File: rtl/pi_digit_pager.sv
// pi_digit_pager: pages through the stored pi result six digits at a time and
// shows the current page on six active-low seven-segment displays.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset with synchronous release
//   key[3:0]            active-low board keys: [0] next, [1] previous, [2] home, [3] unused
//   finish              result valid from the compute engine (level)
//   rd_req / rd_addr    digit read request and digit index
//   rd_ack / rd_data    read acknowledge, with the BCD digit valid in the same cycle
//   hex5..hex0          segment patterns {g,f,e,d,c,b,a}, active-low, hex5 leftmost
//   page_base           digit index shown on hex5
//
// Build option: define PAGER_DEBOUNCE_EN to add a DEB_CYCLES stability filter
// on each key after its synchronizer.
module pi_digit_pager #(
    parameter int unsigned DIGITS     = 96,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        key,
    input  logic              finish,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [3:0]        rd_data,
    output logic [6:0]        hex5,
    output logic [6:0]        hex4,
    output logic [6:0]        hex3,
    output logic [6:0]        hex2,
    output logic [6:0]        hex1,
    output logic [6:0]        hex0,
    output logic [ADDR_W-1:0] page_base
);

    localparam int unsigned SLOTS     = 6;
    localparam int unsigned AW1       = ADDR_W + 1;
    localparam int unsigned LAST      = ((DIGITS - 1) / SLOTS) * SLOTS;
    localparam logic [2:0]  LAST_SLOT = 3'd5;
    localparam logic [3:0]  BLANK_DIG = 4'hF;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_ACK, SHOW} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_NEXT, CMD_PREV, CMD_HOME} cmd_t;

    // Reset: asserts immediately, releases on the second clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Key synchronizers; released level is 1.
    logic [2:0] key_meta_q;
    logic [2:0] key_sync_q;
    logic [2:0] key_lvl_c;
    logic       unused_c;

    assign unused_c = key[3];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
        end else begin
            key_meta_q <= key[2:0];
            key_sync_q <= key_meta_q;
        end
    end

`ifdef PAGER_DEBOUNCE_EN
    // A new level is accepted once DEB_CYCLES consecutive samples disagree with the current one.
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] deb_cnt_q [3];
    logic [CNT_W-1:0] deb_cnt_d [3];
    logic [2:0]       key_lvl_q;
    logic [2:0]       key_lvl_d;

    always_comb begin
        key_lvl_d = key_lvl_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (key_sync_q[i] != key_lvl_q[i]) begin
                if (32'(deb_cnt_q[i]) >= DEB_CYCLES - 1) begin
                    key_lvl_d[i] = key_sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            key_lvl_q <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            key_lvl_q <= key_lvl_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign key_lvl_c = key_lvl_q;
`else
    logic unused_deb_c;

    assign unused_deb_c = ^DEB_CYCLES;
    assign key_lvl_c    = key_sync_q;
`endif

    // Press = falling edge of the accepted level; home > next > prev.
    logic [2:0] key_prev_q;
    logic [2:0] key_fall_c;
    cmd_t       cmd_c;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            key_prev_q <= 3'b111;
        end else begin
            key_prev_q <= key_lvl_c;
        end
    end

    assign key_fall_c = key_prev_q & ~key_lvl_c;

    always_comb begin
        cmd_c = CMD_NONE;
        if (key_fall_c[2]) begin
            cmd_c = CMD_HOME;
        end else if (key_fall_c[0]) begin
            cmd_c = CMD_NEXT;
        end else if (key_fall_c[1]) begin
            cmd_c = CMD_PREV;
        end
    end

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes render blank.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'h40;
            4'd1:    seg_enc = 7'h79;
            4'd2:    seg_enc = 7'h24;
            4'd3:    seg_enc = 7'h30;
            4'd4:    seg_enc = 7'h19;
            4'd5:    seg_enc = 7'h12;
            4'd6:    seg_enc = 7'h02;
            4'd7:    seg_enc = 7'h78;
            4'd8:    seg_enc = 7'h00;
            4'd9:    seg_enc = 7'h10;
            default: seg_enc = SEG_BLANK;
        endcase
    endfunction

    // New page base for a command, wrapping at both ends.
    function automatic logic [ADDR_W-1:0] step_base(input cmd_t cmd, input logic [ADDR_W-1:0] base);
        logic [AW1-1:0] fwd;
        fwd = {1'b0, base} + AW1'(SLOTS);
        case (cmd)
            CMD_HOME: step_base = '0;
            CMD_NEXT: step_base = (32'(fwd) >= DIGITS) ? '0 : fwd[ADDR_W-1:0];
            CMD_PREV: step_base = (32'(base) < SLOTS) ? ADDR_W'(LAST) : base - ADDR_W'(SLOTS);
            default:  step_base = base;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        slot_idx_q, slot_idx_d;
    logic [3:0]        slot_q [SLOTS];
    logic [3:0]        slot_d [SLOTS];
    logic [6:0]        hex_q [SLOTS];
    logic [6:0]        hex_d [SLOTS];
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] page_base_q, page_base_d;
    cmd_t              pend_q, pend_d;
    cmd_t              apply_c;
    logic [AW1-1:0]    slot_addr_c;

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        slot_idx_d  = slot_idx_q;
        slot_d      = slot_q;
        hex_d       = hex_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        page_base_d = page_base_q;
        pend_d      = pend_q;
        apply_c     = CMD_NONE;
        slot_addr_c = {1'b0, page_base_q} + AW1'(slot_idx_q);

        if (!finish) begin
            // Result withdrawn: blank display, drop any request, forget commands.
            state_d    = IDLE;
            slot_idx_d = '0;
            rd_req_d   = 1'b0;
            pend_d     = CMD_NONE;
            for (int k = 0; k < SLOTS; k++) begin
                hex_d[k] = SEG_BLANK;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    pend_d     = CMD_NONE;
                    slot_idx_d = '0;
                    state_d    = FETCH;
                end
                FETCH: begin
                    if (cmd_c != CMD_NONE) begin
                        pend_d = cmd_c;
                    end
                    if (32'(slot_addr_c) >= DIGITS) begin
                        // Past the end of the result: blank slot, no bus cycle.
                        slot_d[slot_idx_q] = BLANK_DIG;
                        if (slot_idx_q == LAST_SLOT) begin
                            state_d = SHOW;
                        end else begin
                            slot_idx_d = slot_idx_q + 3'd1;
                        end
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = slot_addr_c[ADDR_W-1:0];
                        state_d   = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (cmd_c != CMD_NONE) begin
                        pend_d = cmd_c;
                    end
                    if (rd_ack) begin
                        slot_d[slot_idx_q] = rd_data;
                        rd_req_d           = 1'b0;
                        if (slot_idx_q == LAST_SLOT) begin
                            state_d = SHOW;
                        end else begin
                            slot_idx_d = slot_idx_q + 3'd1;
                            state_d    = FETCH;
                        end
                    end
                end
                SHOW: begin
                    for (int k = 0; k < SLOTS; k++) begin
                        hex_d[k] = seg_enc(slot_q[k]);
                    end
                    // A held-over command wins; a press in the same cycle is kept for later.
                    if (pend_q != CMD_NONE) begin
                        apply_c = pend_q;
                        pend_d  = cmd_c;
                    end else begin
                        apply_c = cmd_c;
                    end
                    if (apply_c != CMD_NONE) begin
                        page_base_d = step_base(apply_c, page_base_q);
                        slot_idx_d  = '0;
                        state_d     = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            slot_idx_q  <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            page_base_q <= '0;
            pend_q      <= CMD_NONE;
            for (int k = 0; k < SLOTS; k++) begin
                slot_q[k] <= BLANK_DIG;
                hex_q[k]  <= SEG_BLANK;
            end
        end else begin
            state_q     <= state_d;
            slot_idx_q  <= slot_idx_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            page_base_q <= page_base_d;
            pend_q      <= pend_d;
            for (int k = 0; k < SLOTS; k++) begin
                slot_q[k] <= slot_d[k];
                hex_q[k]  <= hex_d[k];
            end
        end
    end

    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign page_base = page_base_q;
    assign hex5      = hex_q[0];
    assign hex4      = hex_q[1];
    assign hex3      = hex_q[2];
    assign hex2      = hex_q[3];
    assign hex1      = hex_q[4];
    assign hex0      = hex_q[5];

endmodule

// File: tb/tb_pi_digit_pager.sv
// Directed bench for pi_digit_pager: a 96-digit instance and a 10-digit
// instance share keys and finish; each has its own read responder with
// a programmable request-to-acknowledge latency.
`timescale 1ns/1ps
module tb_pi_digit_pager;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEB    = 16;
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    logic              clk;
    logic              rst_n;
    logic [3:0]        key;
    logic              finish;

    logic              rd_req_a, rd_ack_a;
    logic [ADDR_W-1:0] rd_addr_a, pb_a;
    logic [3:0]        rd_data_a;
    logic [6:0]        h5_a, h4_a, h3_a, h2_a, h1_a, h0_a;

    logic              rd_req_b, rd_ack_b;
    logic [ADDR_W-1:0] rd_addr_b, pb_b;
    logic [3:0]        rd_data_b;
    logic [6:0]        h5_b, h4_b, h3_b, h2_b, h1_b, h0_b;

    logic [3:0] mem [0:99];
    string      pi_s;
    int         lat;
    int         req_a, req_b, unstable, bad_b;
    int         n_cmp, n_err;

    pi_digit_pager #(.DIGITS(96), .ADDR_W(ADDR_W), .DEB_CYCLES(DEB)) u_dut (
        .clk(clk), .rst_n(rst_n), .key(key), .finish(finish),
        .rd_req(rd_req_a), .rd_addr(rd_addr_a), .rd_ack(rd_ack_a), .rd_data(rd_data_a),
        .hex5(h5_a), .hex4(h4_a), .hex3(h3_a), .hex2(h2_a), .hex1(h1_a), .hex0(h0_a),
        .page_base(pb_a)
    );

    pi_digit_pager #(.DIGITS(10), .ADDR_W(ADDR_W), .DEB_CYCLES(DEB)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .key(key), .finish(finish),
        .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_ack(rd_ack_b), .rd_data(rd_data_b),
        .hex5(h5_b), .hex4(h4_b), .hex3(h3_b), .hex2(h2_b), .hex1(h1_b), .hex0(h0_b),
        .page_base(pb_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    // Expected {hex5..hex0} for a page starting at base on an ndig-digit result.
    function automatic logic [41:0] page_exp(input int base, input int ndig);
        logic [41:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            r = {r[34:0], ((base + k) < ndig) ? seg(mem[base + k]) : 7'h7F};
        end
        return r;
    endfunction

    // Responder for the 96-digit instance.
    initial begin
        int w;
        logic pr;
        logic [ADDR_W-1:0] pa;
        rd_ack_a = 1'b0; rd_data_a = 4'h0; w = 0; pr = 1'b0; pa = '0;
        forever begin
            @(negedge clk);
            if (rd_req_a) begin
                if (!pr) begin
                    req_a++;
                    w = 0;
                end else if (rd_addr_a != pa) begin
                    unstable++;
                end
                w++;
                rd_ack_a  = (w == lat);
                rd_data_a = (w == lat && rd_addr_a < 100) ? mem[rd_addr_a] : 4'h0;
            end else begin
                rd_ack_a = 1'b0;
                w = 0;
            end
            pr = rd_req_a;
            pa = rd_addr_a;
        end
    end

    // Responder for the 10-digit instance; flags any request past the end.
    initial begin
        int w;
        logic pr;
        logic [ADDR_W-1:0] pa;
        rd_ack_b = 1'b0; rd_data_b = 4'h0; w = 0; pr = 1'b0; pa = '0;
        forever begin
            @(negedge clk);
            if (rd_req_b) begin
                if (rd_addr_b >= 10) bad_b++;
                if (!pr) begin
                    req_b++;
                    w = 0;
                end else if (rd_addr_b != pa) begin
                    unstable++;
                end
                w++;
                rd_ack_b  = (w == lat);
                rd_data_b = (w == lat && rd_addr_b < 100) ? mem[rd_addr_b] : 4'h0;
            end else begin
                rd_ack_b = 1'b0;
                w = 0;
            end
            pr = rd_req_b;
            pa = rd_addr_b;
        end
    end

    // Hold the keys in mask low long enough to pass the filter, release, then settle.
    task automatic press(input logic [3:0] mask, input int settle);
        @(negedge clk);
        key = ~mask;
        repeat (24) @(negedge clk);
        key = 4'hF;
        repeat (24 + settle) @(negedge clk);
    endtask

    initial begin
        int cyc;
        bit done;
        n_cmp = 0; n_err = 0; req_a = 0; req_b = 0; unstable = 0; bad_b = 0;
        lat = 2;
        pi_s = "3141592653589793238462643383279502884197169399375105820974944592307816406286208998628034825342117067";
        for (int i = 0; i < 100; i++) mem[i] = 4'(pi_s[i] - 8'd48);

        rst_n = 1'b0; key = 4'hF; finish = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_req", 64'(rd_req_a), 64'(0));
        check_eq("rst_rd_addr", 64'(rd_addr_a), 64'(0));
        check_eq("rst_page_base", 64'(pb_a), 64'(0));
        check_eq("rst_hex", 64'({h5_a, h4_a, h3_a, h2_a, h1_a, h0_a}), 64'(ALL_BLANK));

        // First page: one edge to leave IDLE, then 6*(2+1)+1 to a loaded display.
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        finish = 1'b1;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (h5_a != 7'h7F) done = 1'b1;
        end
        check_eq("first_latency", 64'(cyc), 64'(20));
        check_eq("first_hex", 64'({h5_a, h4_a, h3_a, h2_a, h1_a, h0_a}),
                 64'({7'h30, 7'h79, 7'h19, 7'h79, 7'h12, 7'h10}));
        repeat (5) @(negedge clk);
        check_eq("first_req_pulses", 64'(req_a), 64'(6));
        check_eq("first_hex10", 64'({h5_b, h4_b, h3_b, h2_b, h1_b, h0_b}), 64'(page_exp(0, 10)));

        // next: 0 -> 6; the short instance blanks slots 10 and 11 without reading them.
        press(4'b0001, 10);
        check_eq("next_pb", 64'(pb_a), 64'(6));
        check_eq("next_hex", 64'({h5_a, h4_a, h3_a, h2_a, h1_a, h0_a}), 64'(page_exp(6, 96)));
        check_eq("next_req", 64'(req_a), 64'(12));
        check_eq("next_pb10", 64'(pb_b), 64'(6));
        check_eq("next_hex10", 64'({h5_b, h4_b, h3_b, h2_b, h1_b, h0_b}),
                 64'({7'h24, 7'h02, 7'h12, 7'h30, 7'h7F, 7'h7F}));
        check_eq("next_req10", 64'(req_b), 64'(10));

        press(4'b0100, 10);
        check_eq("home_pb", 64'(pb_a), 64'(0));
        check_eq("home_pb10", 64'(pb_b), 64'(0));

        // prev at 0 wraps to LAST (90 for 96 digits, 6 for 10 digits).
        press(4'b0010, 10);
        check_eq("prev_wrap_pb", 64'(pb_a), 64'(90));
        check_eq("prev_wrap_hex", 64'({h5_a, h4_a, h3_a, h2_a, h1_a, h0_a}), 64'(page_exp(90, 96)));
        check_eq("prev_wrap_pb10", 64'(pb_b), 64'(6));

        press(4'b0001, 10);
        check_eq("next_wrap_pb", 64'(pb_a), 64'(0));
        check_eq("next_wrap_pb10", 64'(pb_b), 64'(0));

        // next and prev together: next wins.
        press(4'b0011, 10);
        check_eq("both_pb", 64'(pb_a), 64'(6));

        // home pressed while a slow fetch is in flight is held until SHOW.
        lat = 60;
        press(4'b0001, 0);
        press(4'b0100, 0);
        check_eq("pend_mid_pb", 64'(pb_a), 64'(12));
        repeat (900) @(negedge clk);
        check_eq("pend_done_pb", 64'(pb_a), 64'(0));
        check_eq("pend_done_hex", 64'({h5_a, h4_a, h3_a, h2_a, h1_a, h0_a}), 64'(page_exp(0, 96)));

        // Drop finish while a request is outstanding.
        @(negedge clk);
        key = 4'hE;
        repeat (24) @(negedge clk);
        key = 4'hF;
        cyc = 0;
        while (!rd_req_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("drop_req_seen", 64'(rd_req_a), 64'(1));
        finish = 1'b0;
        @(posedge clk);
        #1;
        check_eq("drop_rd_req", 64'(rd_req_a), 64'(0));
        check_eq("drop_hex", 64'({h5_a, h4_a, h3_a, h2_a, h1_a, h0_a}), 64'(ALL_BLANK));
        check_eq("drop_pb_kept", 64'(pb_a), 64'(6));
        repeat (30) @(negedge clk);

        // Reset mid-fetch takes effect between clock edges.
        lat = 2;
        finish = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rd_req", 64'(rd_req_a), 64'(0));
        check_eq("arst_rd_addr", 64'(rd_addr_a), 64'(0));
        check_eq("arst_pb", 64'(pb_a), 64'(0));
        check_eq("arst_hex", 64'({h5_a, h4_a, h3_a, h2_a, h1_a, h0_a}), 64'(ALL_BLANK));

        // Three-cycle glitch on key[0].
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        key = 4'hE;
        repeat (3) @(negedge clk);
        key = 4'hF;
        repeat (60) @(negedge clk);
`ifdef PAGER_DEBOUNCE_EN
        check_eq("glitch_pb", 64'(pb_a), 64'(0));
`else
        check_eq("glitch_pb", 64'(pb_a), 64'(6));
`endif

        check_eq("no_read_past_end", 64'(bad_b), 64'(0));
        check_eq("addr_stable", 64'(unstable), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pi_digit_pager.md
PI_DIGIT_PAGER -- requirements
Module: pi_digit_pager

Interface
REQ-001 SHALL have parameter DIGITS, default 96: number of stored result digits, 1..1024.
REQ-002 SHALL have parameter ADDR_W, default 10: width of the digit address.
REQ-003 SHALL have parameter DEB_CYCLES, default 50000: number of stable cycles required to accept a key level.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port key  input  4: board keys, active-low. key[0] next page, key[1] previous page, key[2] home, key[3] unused.
REQ-007 SHALL have port finish  input  1: compute engine result valid; level-sensitive.
REQ-008 SHALL have port rd_req  output  1: digit read request.
REQ-009 SHALL have port rd_addr  output  ADDR_W: digit index requested.
REQ-010 SHALL have port rd_ack  input  1: read acknowledge; rd_data is valid in the same cycle.
REQ-011 SHALL have port rd_data  input  4: BCD digit.
REQ-012 SHALL have ports hex5..hex0  output  7 each: seven-segment patterns, active-low, segment order {g,f,e,d,c,b,a}. hex5 is the leftmost digit.
REQ-013 SHALL have port page_base  output  ADDR_W: index of the digit shown on hex5.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, WAIT_ACK, SHOW.
- IDLE -> FETCH when finish = 1.
- FETCH -> WAIT_ACK on the same edge that asserts rd_req.
- WAIT_ACK -> FETCH when rd_ack = 1 and digits remain; WAIT_ACK -> SHOW when rd_ack = 1 on the 6th digit.
- SHOW -> FETCH on an accepted page command.
- Any state -> IDLE when finish = 0.
REQ-015 SHALL hold rd_req high and rd_addr stable from assertion until rd_ack is sampled high, and SHALL deassert rd_req in the cycle after the ack; at most one request is outstanding.
REQ-016 SHALL capture rd_data in the rd_ack cycle into slot k (k = 0..5); the slot k digit addresses page_base+k.
REQ-017 SHALL not issue a read for an address >= DIGITS; such a slot is loaded as blank without a bus cycle.
REQ-018 SHALL update hex5..hex0 together, one cycle after the last slot is loaded, and SHALL hold them constant during fetches.
REQ-019 SHALL encode 0-9 as standard active-low patterns (0 = 7'h40, 1 = 7'h79, 3 = 7'h30, 4 = 7'h19); values 10-15 and blank slots SHALL encode as 7'h7F.
REQ-020 SHALL handle page commands as follows:
- next: page_base += 6; wraps to 0 when the result would be >= DIGITS.
- prev: page_base -= 6; at 0, wraps to LAST = ((DIGITS-1)/6)*6.
- home: page_base = 0.
REQ-021 SHALL detect a key press as a falling edge of the debounced key.
REQ-022 SHALL resolve simultaneous presses with priority home > next > prev.
REQ-023 SHALL latch one press that arrives outside SHOW as a pending command (the newest press overwrites), and SHALL apply it on entering SHOW.
REQ-024 SHALL drive all hex outputs to 7'h7F in IDLE, clear the pending command, keep page_base, and abandon any outstanding request (rd_req = 0 in the next cycle).
REQ-025 SHALL make FETCH-to-SHOW latency 6 × (req-to-ack cycles + 1) + 1 cycles.

Reset
REQ-026 SHALL, while rst_n = 0, set state = IDLE, rd_req = 0, rd_addr = 0, page_base = 0, hex5..hex0 = 7'h7F, all slots blank, pending command cleared, debounce counters 0, and key synchronizers to 1 (released).
REQ-027 SHALL assert reset asynchronously and release it synchronously through a 2-flop synchronizer; the first FSM transition occurs no earlier than the 2nd edge after release.

Configuration
REQ-028 SHALL support macro PAGER_DEBOUNCE_EN.
- Defined: each key passes through a 2-flop synchronizer and a counter, and a level is accepted after DEB_CYCLES consecutive equal samples.
- Undefined: keys pass only through the 2-flop synchronizer; an edge is detected directly on the synchronized level, and DEB_CYCLES is ignored.

Verification
REQ-029 Memory holds 3,1,4,1,5,9,2,6,...; finish raised with ack latency 2 → hex5..hex0 = 7'h30,7'h79,7'h19,7'h79,7'h12,7'h10; rd_req pulses exactly 6 times.
REQ-030 key[0] pressed for one debounced period → page_base = 6, addresses 6..11 fetched; with DIGITS = 10, slots 10,11 show 7'h7F and no request to 10/11 is issued.
REQ-031 At page_base = 0, press key[1] with DIGITS = 96 → page_base = 90; then press key[0] → page_base = 0.
REQ-032 Press key[0] and key[1] in the same cycle → next only; press key[2] during WAIT_ACK → pending, then page_base = 0 after SHOW.
REQ-033 Drop finish during WAIT_ACK → rd_req = 0 next cycle, all hex = 7'h7F; assert rst_n = 0 mid-fetch → outputs reach reset values without a clock edge.
REQ-034 With PAGER_DEBOUNCE_EN, a 3-cycle key glitch (DEB_CYCLES = 16) is ignored; without the macro, the same glitch advances one page.
